// File: rtl/led_pattern_ctrl.sv
// ---------------------------------------------------------------------------
// led_pattern_ctrl
//
// Drives the two board LEDs from a single command port. A shared prescaler
// produces a one-cycle `tick` every DIV clocks. Two independent channel state
// machines use that tick to time their on/off phases. Each channel runs one of
// these patterns: OFF, steady ON, free-running BLINK, or a counted BURST.
//
// Build option:
//   LEDCTL_BURST_EN  defined   -> BURST mode, pulse counter, burst flag and
//                                 `done` pulses are built.
//                    undefined -> mode 3 behaves as OFF, `done` is tied 0,
//                                 `cmd_ready` is tied 1.
//
// Parameters:
//   DIV    clock cycles per prescaler tick (>= 2)
//   DIV_W  prescaler counter width, 2**DIV_W >= DIV
//
// Ports:
//   clk, rst_n   system clock (rising edge), asynchronous active-low reset
//   cmd_valid    command present
//   cmd_ready    command can be accepted this cycle
//   cmd_led      target channel: 0 -> led1, 1 -> led2
//   cmd_mode     0 OFF, 1 ON, 2 BLINK, 3 BURST
//   cmd_period   half-period in ticks (0 is treated as 1)
//   cmd_count    BURST pulse count (0 is treated as 1)
//   led1, led2   LED drive, active-high
//   busy[n]      channel n is in any state other than OFF
//   done[n]      one-cycle pulse when a BURST on channel n completes
// ---------------------------------------------------------------------------
module led_pattern_ctrl #(
  parameter int DIV   = 50000,
  parameter int DIV_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_led,
  input  logic [1:0] cmd_mode,
  input  logic [7:0] cmd_period,
  input  logic [3:0] cmd_count,
  output logic       led1,
  output logic       led2,
  output logic [1:0] busy,
  output logic [1:0] done
);

  // Channel states.
  localparam logic [1:0] ST_OFF = 2'd0;
  localparam logic [1:0] ST_ON  = 2'd1;
  localparam logic [1:0] ST_HI  = 2'd2;
  localparam logic [1:0] ST_LO  = 2'd3;

  // Command modes.
  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_ON    = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;
  localparam logic [1:0] MODE_BURST = 2'd3;

  localparam logic [DIV_W-1:0] PRE_LAST = DIV_W'(DIV - 1);

  // -------------------------------------------------------------------------
  // Prescaler: free-running 0..DIV-1, never disturbed by commands.
  // -------------------------------------------------------------------------
  logic [DIV_W-1:0] pre_cnt;
  logic             tick;

  assign tick = (pre_cnt == PRE_LAST);

  // NOTE: sequential state is always updated with non-blocking assignments so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + DIV_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Command decode. Zero period/count are promoted to 1 at load so the
  // down-counters never have to handle a zero value.
  // -------------------------------------------------------------------------
  logic [7:0] period_eff;
  logic       take;
  logic [1:0] accept;
  logic [1:0] led_int;

  assign period_eff = (cmd_period == 8'd0) ? 8'd1 : cmd_period;
  assign take       = cmd_valid & cmd_ready;
  assign accept[0]  = take & ~cmd_led;
  assign accept[1]  = take &  cmd_led;

`ifdef LEDCTL_BURST_EN
  logic [3:0] count_eff;
  logic [1:0] in_burst;

  assign count_eff = (cmd_count == 4'd0) ? 4'd1 : cmd_count;

  // Only a running burst pushes back, and only for non-OFF commands: OFF is
  // always taken so the host can abort a burst at any time.
  assign cmd_ready = !(in_burst[cmd_led] && (cmd_mode != MODE_OFF));
`else
  logic unused_count;

  assign unused_count = ^cmd_count;
  assign cmd_ready    = 1'b1;
  assign done         = 2'b00;
`endif

  // -------------------------------------------------------------------------
  // Per-channel pattern state machines.
  // -------------------------------------------------------------------------
  for (genvar g = 0; g < 2; g++) begin : g_ch
    logic [1:0] state;
    logic [7:0] ph;   // ticks left in the current HI/LO phase
    logic [7:0] per;  // latched half-period, reloaded at every phase end
`ifdef LEDCTL_BURST_EN
    logic [3:0] rem;  // pulses left, including the one in progress
    logic       burst;
    logic       done_q;

    assign in_burst[g] = burst && (state != ST_OFF);
    assign done[g]     = done_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state  <= ST_OFF;
        ph     <= 8'd1;
        per    <= 8'd1;
`ifdef LEDCTL_BURST_EN
        rem    <= 4'd1;
        burst  <= 1'b0;
        done_q <= 1'b0;
`endif
      end else begin
`ifdef LEDCTL_BURST_EN
        done_q <= 1'b0;
`endif
        // An accepted command takes priority over a coincident tick, so a
        // freshly loaded pattern always starts with the full period in `ph`.
        if (accept[g]) begin
          case (cmd_mode)
            MODE_ON: begin
              state <= ST_ON;
`ifdef LEDCTL_BURST_EN
              burst <= 1'b0;
`endif
            end
            MODE_BLINK: begin
              state <= ST_HI;
              ph    <= period_eff;
              per   <= period_eff;
`ifdef LEDCTL_BURST_EN
              burst <= 1'b0;
`endif
            end
`ifdef LEDCTL_BURST_EN
            MODE_BURST: begin
              state <= ST_HI;
              ph    <= period_eff;
              per   <= period_eff;
              rem   <= count_eff;
              burst <= 1'b1;
            end
`endif
            default: begin
              // MODE_OFF, and MODE_BURST when bursts are not built.
              state <= ST_OFF;
`ifdef LEDCTL_BURST_EN
              burst <= 1'b0;
`endif
            end
          endcase
        end else if (tick && ((state == ST_HI) || (state == ST_LO))) begin
          if (ph != 8'd1) begin
            ph <= ph - 8'd1;
          end else begin
            ph <= per;
            if (state == ST_HI) begin
              state <= ST_LO;
`ifdef LEDCTL_BURST_EN
            end else if (!burst) begin
              state <= ST_HI;
            end else if (rem == 4'd1) begin
              // Last LO phase of the burst: finish and flag completion in
              // the same cycle that busy drops.
              state  <= ST_OFF;
              burst  <= 1'b0;
              done_q <= 1'b1;
            end else begin
              rem   <= rem - 4'd1;
              state <= ST_HI;
            end
`else
            end else begin
              state <= ST_HI;
            end
`endif
          end
        end
      end
    end

    // Outputs decode straight from the state register, no extra stage.
    assign led_int[g] = (state == ST_ON) || (state == ST_HI);
    assign busy[g]    = (state != ST_OFF);
  end

  assign led1 = led_int[0];
  assign led2 = led_int[1];

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// ---------------------------------------------------------------------------
// tb_led_pattern_ctrl
//
// Directed bench for led_pattern_ctrl with DIV=4. Inputs are driven and
// outputs sampled on the falling clock edge. `e` counts rising edges since
// reset release, so prescaler ticks land on edges where e is a multiple of 4.
// The burst scenarios are selected with the same LEDCTL_BURST_EN macro as
// the design.
// ---------------------------------------------------------------------------
module tb_led_pattern_ctrl;

  localparam int DIV = 4;

  localparam logic [1:0] M_OFF   = 2'd0;
  localparam logic [1:0] M_ON    = 2'd1;
  localparam logic [1:0] M_BLINK = 2'd2;
  localparam logic [1:0] M_BURST = 2'd3;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b0;
  logic       cmd_valid  = 1'b0;
  logic       cmd_led    = 1'b0;
  logic [1:0] cmd_mode   = 2'd0;
  logic [7:0] cmd_period = 8'd0;
  logic [3:0] cmd_count  = 4'd0;
  logic       cmd_ready;
  logic       led1;
  logic       led2;
  logic [1:0] busy;
  logic [1:0] done;

  int vectors     = 0;
  int miscompares = 0;
  int e           = 0;
  int a           = 0;
  int t1          = 0;

  always #5 clk = ~clk;

  led_pattern_ctrl #(
    .DIV   (DIV),
    .DIV_W (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_led    (cmd_led),
    .cmd_mode   (cmd_mode),
    .cmd_period (cmd_period),
    .cmd_count  (cmd_count),
    .led1       (led1),
    .led2       (led2),
    .busy       (busy),
    .done       (done)
  );

  function automatic logic [7:0] leds_now();
    return {6'd0, led2, led1};
  endfunction

  function automatic logic [7:0] busy_now();
    return {6'd0, busy};
  endfunction

  function automatic logic [7:0] done_now();
    return {6'd0, done};
  endfunction

  function automatic logic [7:0] ready_now();
    return {7'd0, cmd_ready};
  endfunction

  // First tick edge strictly after edge `at`.
  function automatic int next_tick(input int at);
    return (at / DIV + 1) * DIV;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, e, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    e++;
  endtask

  task automatic run_to(input int target);
    while (e < target) cycle();
  endtask

  task automatic present(input logic l, input logic [1:0] m, input logic [7:0] p,
                         input logic [3:0] c);
    cmd_valid  = 1'b1;
    cmd_led    = l;
    cmd_mode   = m;
    cmd_period = p;
    cmd_count  = c;
  endtask

  // Command accepted on the next rising edge; returns at the falling edge after.
  task automatic send(input logic l, input logic [1:0] m, input logic [7:0] p,
                      input logic [3:0] c);
    present(l, m, p, c);
    cycle();
    cmd_valid = 1'b0;
  endtask

  initial begin
    // ---------------- Reset ----------------
    @(negedge clk);
    check("rst_hold_led",   leds_now(),  8'h00);
    check("rst_hold_busy",  busy_now(),  8'h00);
    check("rst_hold_done",  done_now(),  8'h00);
    check("rst_hold_ready", ready_now(), 8'h01);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    e     = 0;
    for (int i = 0; i < 2; i++) begin
      cycle();
      check("rst_led",   leds_now(),  8'h00);
      check("rst_busy",  busy_now(),  8'h00);
      check("rst_done",  done_now(),  8'h00);
      check("rst_ready", ready_now(), 8'h01);
    end

    // ---------------- ON then OFF (led1) ----------------
    send(1'b0, M_ON, 8'd0, 4'd0);
    check("on_led",  leds_now(), 8'h01);
    check("on_busy", busy_now(), 8'h01);
    for (int i = 0; i < 19; i++) begin
      cycle();
      check("on_hold_led", leds_now(), 8'h01);
    end
    send(1'b0, M_OFF, 8'd0, 4'd0);
    check("off_led",  leds_now(), 8'h00);
    check("off_busy", busy_now(), 8'h00);

    // ---------------- BLINK led2, period 2 ----------------
    send(1'b1, M_BLINK, 8'd2, 4'd0);
    a  = e;
    t1 = next_tick(a);
    check("blink_start_led",  leds_now(), 8'h02);
    check("blink_start_busy", busy_now(), 8'h02);
    run_to(t1 + DIV - 1);
    check("blink_first_hi_end", leds_now(), 8'h02);
    run_to(t1 + DIV);
    check("blink_lo_start", leds_now(), 8'h00);
    check("blink_lo_busy",  busy_now(), 8'h02);
    run_to(t1 + 3 * DIV - 1);
    check("blink_lo_end", leds_now(), 8'h00);
    run_to(t1 + 3 * DIV);
    check("blink_hi2_start", leds_now(), 8'h02);
    run_to(t1 + 5 * DIV - 1);
    check("blink_hi2_end", leds_now(), 8'h02);
    run_to(t1 + 5 * DIV);
    check("blink_lo2_start", leds_now(), 8'h00);
    send(1'b1, M_OFF, 8'd0, 4'd0);
    check("blink_off_busy", busy_now(), 8'h00);

    // ---------------- BLINK with period 0 behaves as period 1 ----------------
    send(1'b1, M_BLINK, 8'd0, 4'd0);
    a  = e;
    t1 = next_tick(a);
    check("p0_start", leds_now(), 8'h02);
    run_to(t1);
    check("p0_lo", leds_now(), 8'h00);
    run_to(t1 + DIV);
    check("p0_hi", leds_now(), 8'h02);
    send(1'b1, M_OFF, 8'd0, 4'd0);

`ifdef LEDCTL_BURST_EN
    // ---------------- BURST led1, period 1, count 3 ----------------
    send(1'b0, M_BURST, 8'd1, 4'd3);
    a  = e;
    t1 = next_tick(a);
    check("burst_start_led",  leds_now(), 8'h01);
    check("burst_start_busy", busy_now(), 8'h01);
    run_to(t1);
    check("burst_p1_end", leds_now(), 8'h00);
    run_to(t1 + DIV);
    check("burst_p2_start", leds_now(), 8'h01);
    run_to(t1 + 2 * DIV - 1);
    check("burst_p2_last", leds_now(), 8'h01);
    run_to(t1 + 2 * DIV);
    check("burst_p2_end", leds_now(), 8'h00);
    run_to(t1 + 3 * DIV);
    check("burst_p3_start", leds_now(), 8'h01);
    run_to(t1 + 4 * DIV);
    check("burst_p3_end", leds_now(), 8'h00);
    run_to(t1 + 5 * DIV - 1);
    check("burst_pre_done", done_now(), 8'h00);
    check("burst_pre_busy", busy_now(), 8'h01);
    run_to(t1 + 5 * DIV);
    check("burst_done",      done_now(), 8'h01);
    check("burst_done_busy", busy_now(), 8'h00);
    check("burst_done_led",  leds_now(), 8'h00);
    cycle();
    check("burst_done_clear", done_now(), 8'h00);

    // ---------------- Backpressure and abort ----------------
    send(1'b0, M_BURST, 8'd1, 4'd3);
    a  = e;
    t1 = next_tick(a);
    present(1'b0, M_BLINK, 8'd5, 4'd0);
    #1;
    check("bp_ready_low", ready_now(), 8'h00);
    cycle();
    check("bp_ready_low2", ready_now(), 8'h00);
    cycle();
    cmd_valid = 1'b0;
    // A wrongly accepted BLINK(5) would still be high here; the burst is in LO.
    run_to(t1 + 2 * DIV);
    check("bp_burst_kept", leds_now(), 8'h00);
    present(1'b1, M_BLINK, 8'd3, 4'd0);
    #1;
    check("bp_other_ready", ready_now(), 8'h01);
    cycle();
    cmd_valid = 1'b0;
    check("bp_other_busy", busy_now(), 8'h03);
    check("bp_other_led2", {7'd0, led2}, 8'h01);
    present(1'b0, M_OFF, 8'd0, 4'd0);
    #1;
    check("abort_ready", ready_now(), 8'h01);
    cycle();
    cmd_valid = 1'b0;
    check("abort_led1", {7'd0, led1}, 8'h00);
    check("abort_busy", busy_now(),   8'h02);
    for (int i = 0; i < 24; i++) begin
      cycle();
      check("abort_no_done", done_now(), 8'h00);
    end
    send(1'b1, M_OFF, 8'd0, 4'd0);

    // ---------------- BURST count 0 behaves as one pulse ----------------
    send(1'b1, M_BURST, 8'd1, 4'd0);
    a  = e;
    t1 = next_tick(a);
    check("c0_start", leds_now(), 8'h02);
    run_to(t1 + DIV - 1);
    check("c0_pre_done", done_now(), 8'h00);
    check("c0_pre_busy", busy_now(), 8'h02);
    run_to(t1 + DIV);
    check("c0_done",      done_now(), 8'h02);
    check("c0_done_busy", busy_now(), 8'h00);
    cycle();
    check("c0_done_clear", done_now(), 8'h00);
`else
    // ---------------- Mode 3 without bursts behaves as OFF ----------------
    send(1'b0, M_BURST, 8'd1, 4'd3);
    check("m3_led",   leds_now(),  8'h00);
    check("m3_busy",  busy_now(),  8'h00);
    check("m3_ready", ready_now(), 8'h01);
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("m3_done", done_now(), 8'h00);
    end
`endif

    // ---------------- Accept on a tick edge: full period loaded ----------------
    run_to(next_tick(e) - 1);
    send(1'b0, M_BLINK, 8'd2, 4'd0);
    a = e;
    check("coll_on_tick_edge", 8'((a % DIV) == 0), 8'h01);
    check("coll_start", leds_now(), 8'h01);
    run_to(a + DIV);
    check("coll_mid", leds_now(), 8'h01);
    run_to(a + 2 * DIV - 1);
    check("coll_last_hi", leds_now(), 8'h01);
    run_to(a + 2 * DIV);
    check("coll_lo", leds_now(), 8'h00);

    // ---------------- Asynchronous reset mid-pattern ----------------
`ifdef LEDCTL_BURST_EN
    send(1'b1, M_BURST, 8'd3, 4'd4);
`else
    send(1'b1, M_ON, 8'd0, 4'd0);
`endif
    check("pre_reset_led2", {7'd0, led2}, 8'h01);
    present(1'b1, M_BLINK, 8'd2, 4'd0);
    rst_n = 1'b0;
    #1;
    check("arst_led",   leds_now(),  8'h00);
    check("arst_busy",  busy_now(),  8'h00);
    check("arst_done",  done_now(),  8'h00);
    check("arst_ready", ready_now(), 8'h01);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    e     = 0;
    cycle();
    check("post_reset_led",  leds_now(), 8'h00);
    check("post_reset_busy", busy_now(), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
